// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Brief    : Serial line plus byte holding-register handshake of uart_rx.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd;
    logic       clr_err;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rxd, rd, clr_err,
        input  rx_data, rx_valid, framing_err, overrun, busy
    );

    modport slave (
        input  rxd, rd, clr_err,
        output rx_data, rx_valid, framing_err, overrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver with byte holding register, valid/read
//             handshake and sticky framing-error / overrun flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLOCK_FREQ = 10000000,
    parameter int BAUD       = 115200
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);

    localparam int c_DIV  = (CLOCK_FREQ + BAUD / 2) / BAUD;
    localparam int c_HALF = c_DIV / 2;
    localparam int c_CW   = $clog2(c_DIV);

    localparam logic [c_CW-1:0] c_DIV_LAST  = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state, w_state_nx;
    logic [c_CW-1:0] r_cnt,   w_cnt_nx;
    logic [2:0]      r_bit,   w_bit_nx;
    logic [7:0]      r_shift, w_shift_nx;
    logic [7:0]      r_data,  w_data_nx;
    logic            r_valid, w_valid_nx;
    logic            r_ferr,  w_ferr_nx;
    logic            r_ovr,   w_ovr_nx;
    logic            w_sample;

    logic            r_sync1;
    logic            r_rxd_s;
    logic            r_rxd_p;
    logic [1:0]      r_fill;
    logic            r_armed;

    // The sync flops reset high, so their first post-reset values are not
    // real line samples; r_fill tracks when r_rxd_s carries a genuine sample
    // and r_armed insists on a real high before any falling edge counts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
            r_rxd_p <= 1'b1;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= bus.rxd;
            r_rxd_s <= r_sync1;
            r_rxd_p <= r_rxd_s;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_rxd_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_ferr  <= w_ferr_nx;
            r_ovr   <= w_ovr_nx;
        end
    end

    assign w_sample = (r_state == S_START) ? (r_cnt == c_HALF_LAST)
                                           : (r_cnt == c_DIV_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = w_sample ? '0 : r_cnt + 1'b1;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_valid_nx = r_valid & ~bus.rd;
        w_ferr_nx  = r_ferr  & ~bus.clr_err;
        w_ovr_nx   = r_ovr   & ~bus.clr_err;

        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (r_armed && !r_rxd_s && r_rxd_p) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_sample) begin
                    if (r_rxd_s) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_DATA;
                        w_bit_nx   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    w_shift_nx = {r_rxd_s, r_shift[7:1]};
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nx = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Error sets are applied after the clears so a new event wins.
                if (w_sample) begin
                    w_state_nx = S_IDLE;
                    if (r_rxd_s) begin
                        w_data_nx  = r_shift;
                        w_valid_nx = 1'b1;
                        if (r_valid && !bus.rd) begin
                            w_ovr_nx = 1'b1;
                        end
                    end else begin
                        w_ferr_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.framing_err = r_ferr;
    assign bus.overrun     = r_ovr;
    assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
